// File: rtl/hazard_controller_if.sv
// Hazard controller interface: groups the pipeline-side hazard inputs and the
// controller's stall/flush/forward/memory-request outputs.
//   master : pipeline/testbench side (drives register indices, enables, MemAck)
//   slave  : hazard controller side (drives stalls, flushes, forwards, counters)
interface hazard_controller_if;
  // Register indices from Decode, Execute, Memory and Writeback
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [4:0]  RdM;
  logic [4:0]  RdW;
  // Pipeline status
  logic        RegWriteM;
  logic        RegWriteW;
  logic        LoadE;
  logic        PCSrcE;
  logic        MemAccessM;
  logic        MemAck;
  // Controller outputs
  logic        MemReq;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
  logic        MemTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, MemAck,
    input  MemReq, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, ForwardAE, ForwardBE,
    input  StallCount, FlushCount, MemTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemAccessM, MemAck,
    output MemReq, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, ForwardAE, ForwardBE,
    output StallCount, FlushCount, MemTimeout
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for a five-stage pipeline.
// Detects load-use and data-memory wait hazards, produces stall/flush controls,
// selects ALU operand forwarding, keeps stall/flush performance counters and a
// sticky watchdog for memory requests that never complete.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   hif  : hazard_controller_if.slave (pipeline indices/status in; stall, flush,
//          forward, MemReq, StallCount, FlushCount, MemTimeout out)
module hazard_controller (
  input  logic               clk,
  input  logic               rst,
  hazard_controller_if.slave hif
);

  localparam int unsigned RegIdxW = 5;
  localparam int unsigned CntW    = 16;
  localparam int unsigned WaitW   = 8;

  localparam logic [CntW-1:0]    CntMax     = '1;
  localparam logic [WaitW-1:0]   WaitMax    = '1;
  localparam logic [WaitW-1:0]   WaitPreMax = WaitW'(254);
  localparam logic [RegIdxW-1:0] RegZero    = '0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic              memReq;
  logic              memStall;
  logic              lwStall;
  logic              branchTaken;
  logic              stallFD;
  logic              flushD;
  logic [1:0]        fwdA;
  logic [1:0]        fwdB;
  logic [WaitW-1:0]  waitCnt;
  logic [CntW-1:0]   stallCnt;
  logic [CntW-1:0]   flushCnt;
  logic              memTimeout;

  // Forward select for one Execute source: Memory result wins over Writeback; x0 never forwards
  function automatic logic [1:0] fwdSel(
    input logic [RegIdxW-1:0] rs,
    input logic               regWriteM,
    input logic [RegIdxW-1:0] rdM,
    input logic               regWriteW,
    input logic [RegIdxW-1:0] rdW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (regWriteM && (rdM != RegZero) && (rdM == rs)) begin
      sel = 2'b10;
    end else if (regWriteW && (rdW != RegZero) && (rdW == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Next-state and memory request; reset abandons an outstanding request immediately
  always_comb begin
    stateNext = state;
    memReq    = 1'b0;
    case (state)
      RUN: begin
        memReq = hif.MemAccessM;
        if (hif.MemAccessM && !hif.MemAck) begin
          stateNext = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        memReq = 1'b1;
        if (hif.MemAck) begin
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
    if (rst) begin
      memReq    = 1'b0;
      stateNext = RUN;
    end
  end

  // Hazard detection; everything is quiet while reset is held
  always_comb begin
    memStall    = memReq && !hif.MemAck;
    lwStall     = !rst && hif.LoadE && (hif.RdE != RegZero) &&
                  ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
    branchTaken = !rst && hif.PCSrcE;
    stallFD     = lwStall || memStall;
    // A frozen Execute stage must not be flushed; the branch lands once the memory stall clears
    flushD      = branchTaken && !memStall;
    fwdA        = 2'b00;
    fwdB        = 2'b00;
    if (!rst) begin
      fwdA = fwdSel(hif.Rs1E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
      fwdB = fwdSel(hif.Rs2E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
    end
  end

  assign hif.MemReq     = memReq;
  assign hif.StallF     = stallFD;
  assign hif.StallD     = stallFD;
  assign hif.StallE     = memStall;
  assign hif.StallM     = memStall;
  assign hif.FlushD     = flushD;
  assign hif.FlushE     = (lwStall || branchTaken) && !memStall;
  assign hif.FlushW     = memStall;
  assign hif.ForwardAE  = fwdA;
  assign hif.ForwardBE  = fwdB;
  assign hif.StallCount = stallCnt;
  assign hif.FlushCount = flushCnt;
  assign hif.MemTimeout = memTimeout;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Wait counter, sticky watchdog and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt    <= '0;
      memTimeout <= 1'b0;
      stallCnt   <= '0;
      flushCnt   <= '0;
    end else begin
      if ((state == RUN) && (stateNext == MEM_WAIT)) begin
        waitCnt <= '0;
      end else if ((state == MEM_WAIT) && (waitCnt != WaitMax)) begin
        waitCnt <= waitCnt + WaitW'(1);
      end
      // Flag on the edge where the wait counter reaches its limit with no ack
      if ((state == MEM_WAIT) && !hif.MemAck && (waitCnt == WaitPreMax)) begin
        memTimeout <= 1'b1;
      end
      if (stallFD && (stallCnt != CntMax)) begin
        stallCnt <= stallCnt + CntW'(1);
      end
      if (flushD && (flushCnt != CntMax)) begin
        flushCnt <= flushCnt + CntW'(1);
      end
    end
  end

endmodule
